// File: rtl/adc_capture_fifo_if.sv
// Consumer-side sample stream of adc_capture_fifo: first-word-fall-through head with valid/ready.
interface adc_capture_fifo_if #(
   parameter int OUT_WIDTH = 16
);
   logic [OUT_WIDTH-1:0] sampleData;
   logic                 sampleValid;
   logic                 sampleReady;

   modport master (output sampleData, output sampleValid, input sampleReady);
   modport slave  (input sampleData, input sampleValid, output sampleReady);
endinterface

// File: rtl/adc_capture_fifo.sv
// Negedge ADC capture stage: input register, left-justify, FWFT FIFO, sticky overflow, clip counter.
// Optional ADC_TEST_PATTERN_EN: testMode selects an internal ADC_WIDTH-bit ramp instead of adcDatabus.
module adc_capture_fifo #(
   parameter int ADC_WIDTH  = 10,
   parameter int OUT_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 nReset,
   input  logic                 runFlag,
   input  logic                 testMode,
   input  logic [ADC_WIDTH-1:0] adcDatabus,
   adc_capture_fifo_if.master   sampleBus,
   output logic                 overflow,
   output logic [15:0]          clipCount
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int SHIFT = OUT_WIDTH - ADC_WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t               stateReg, stateNext;
   logic                 doCapture, runStart;
   logic [ADC_WIDTH-1:0] captureValue;
   logic [ADC_WIDTH-1:0] inData;
   logic                 inValid;
   logic [OUT_WIDTH-1:0] justified;
   logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W:0]       wrPtr, rdPtr;
   logic                 fifoEmpty, fifoFull, pop, push, isClip;

   always_ff @(negedge clock or negedge nReset) begin
      if (!nReset) stateReg <= IDLE;
      else         stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      doCapture = 1'b0;
      runStart  = 1'b0;
      case (stateReg)
         IDLE: if (runFlag) begin
            stateNext = RUN;
            doCapture = 1'b1;
            runStart  = 1'b1;
         end
         RUN: if (runFlag) doCapture = 1'b1;
              else         stateNext = FLUSH;
         // runFlag is deliberately not sampled here; a restart goes through IDLE
         FLUSH: if (fifoEmpty && !inValid) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

`ifdef ADC_TEST_PATTERN_EN
   logic [ADC_WIDTH-1:0] testCount;
   logic [ADC_WIDTH-1:0] testBase;

   assign testBase     = runStart ? '0 : testCount;
   assign captureValue = testMode ? testBase : adcDatabus;

   always_ff @(negedge clock or negedge nReset) begin
      if (!nReset)        testCount <= '0;
      else if (doCapture) testCount <= testBase + ADC_WIDTH'(1);
   end
`else
   logic unusedTestMode;
   assign unusedTestMode = testMode;
   assign captureValue   = adcDatabus;
`endif

   always_ff @(negedge clock or negedge nReset) begin
      if (!nReset) begin
         inValid <= 1'b0;
         inData  <= '0;
      end else begin
         inValid <= doCapture;
         if (doCapture) inData <= captureValue;
      end
   end

   assign justified = OUT_WIDTH'(inData) << SHIFT;
   assign fifoEmpty = (wrPtr == rdPtr);
   assign fifoFull  = (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]) && (wrPtr[PTR_W] != rdPtr[PTR_W]);
   assign pop       = !fifoEmpty && sampleBus.sampleReady;
   // A pop on the same edge frees the slot the write lands in
   assign push      = inValid && (!fifoFull || pop);
   assign isClip    = inValid && ((inData == '0) || (inData == '1));

   always_ff @(negedge clock) begin
      if (push) mem[wrPtr[PTR_W-1:0]] <= justified;
   end

   always_ff @(negedge clock or negedge nReset) begin
      if (!nReset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(negedge clock or negedge nReset) begin
      if (!nReset) begin
         overflow  <= 1'b0;
         clipCount <= '0;
      end else if (runStart) begin
         overflow  <= 1'b0;
         clipCount <= '0;
      end else begin
         if (inValid && !push) overflow <= 1'b1;
         if (isClip && (clipCount != 16'hFFFF)) clipCount <= clipCount + 16'd1;
      end
   end

   // Head gated to zero when empty so the storage array needs no reset
   assign sampleBus.sampleValid = !fifoEmpty;
   assign sampleBus.sampleData  = fifoEmpty ? '0 : mem[rdPtr[PTR_W-1:0]];
endmodule

// File: tb/tb_adc_capture_fifo.sv
// Randomized bench for adc_capture_fifo against a queue-based model of the capture rules.
module tb_adc_capture_fifo;
   localparam int ADC_W = 10;
   localparam int OUT_W = 16;
   localparam int DEPTH = 4;
   localparam int SHIFT = OUT_W - ADC_W;
   localparam int ALL_ONES = (1 << ADC_W) - 1;

   logic             clock = 1'b0;
   logic             nReset = 1'b0;
   logic             runFlag = 1'b0;
   logic             testMode = 1'b0;
   logic [ADC_W-1:0] adcDatabus = '0;
   logic             overflow;
   logic [15:0]      clipCount;

   adc_capture_fifo_if #(.OUT_WIDTH(OUT_W)) sampleBus ();

   adc_capture_fifo #(
      .ADC_WIDTH(ADC_W),
      .OUT_WIDTH(OUT_W),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clock(clock),
      .nReset(nReset),
      .runFlag(runFlag),
      .testMode(testMode),
      .adcDatabus(adcDatabus),
      .sampleBus(sampleBus),
      .overflow(overflow),
      .clipCount(clipCount)
   );

   always #5 clock = ~clock;

   int checkCount = 0;
   int passCount  = 0;

   // Model: capture phase (0 idle, 1 running, 2 draining), one pending sample, queue of FIFO contents
   int mMode = 0;
   bit mPendValid = 0;
   int mPendVal = 0;
   int q[$];
   bit mOvf = 0;
   int mClip = 0;
   int mCount = 0;
   int popNum = 0;

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      else passCount++;
   endtask

   task automatic modelReset();
      mMode = 0; mPendValid = 0; mPendVal = 0; q.delete();
      mOvf = 0; mClip = 0; mCount = 0;
   endtask

   task automatic modelStep();
      int preSize = q.size();
      bit prePend = mPendValid;
      int preVal  = mPendVal;
      bit pop     = (preSize > 0) && sampleBus.sampleReady;
      bit start   = (mMode == 0) && runFlag;
      bit cap     = (mMode != 2) && runFlag;
      if (pop) begin
         popNum++;
         $display("pop %0d data=%h", popNum, q[0]);
         void'(q.pop_front());
      end
      if (prePend) begin
         if ((preVal == 0 || preVal == ALL_ONES) && mClip < 65535) mClip++;
         if (q.size() < DEPTH) q.push_back(preVal << SHIFT);
         else mOvf = 1;
      end
      if (start) begin
         mOvf = 0; mClip = 0; mCount = 0;
      end
      mPendValid = cap;
      if (cap) begin
`ifdef ADC_TEST_PATTERN_EN
         mPendVal = testMode ? mCount : int'(adcDatabus);
         mCount = (mCount + 1) % (1 << ADC_W);
`else
         mPendVal = int'(adcDatabus);
`endif
      end
      if (mMode == 0 && runFlag) mMode = 1;
      else if (mMode == 1 && !runFlag) mMode = 2;
      else if (mMode == 2 && preSize == 0 && !prePend) mMode = 0;
   endtask

   task automatic compareAll();
      checkValue("valid", 32'(sampleBus.sampleValid), 32'(q.size() > 0));
      checkValue("data", 32'(sampleBus.sampleData), (q.size() > 0) ? q[0] : 0);
      checkValue("overflow", 32'(overflow), 32'(mOvf));
      checkValue("clip", 32'(clipCount), mClip);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clock);
         if (nReset) modelStep();
         else modelReset();
         @(posedge clock);
         #1;
         compareAll();
      end
   endtask

   task automatic goIdle();
      runFlag = 0; testMode = 0; sampleBus.sampleReady = 1;
      step(10);
   endtask

   logic [ADC_W-1:0] clipPat [3];

   initial begin
      sampleBus.sampleReady = 1'b0;
      clipPat[0] = '0; clipPat[1] = '1; clipPat[2] = 10'h200;
      @(posedge clock); #1;
      checkValue("rst_valid", 32'(sampleBus.sampleValid), 0);
      checkValue("rst_data", 32'(sampleBus.sampleData), 0);
      checkValue("rst_ovf", 32'(overflow), 0);
      checkValue("rst_clip", 32'(clipCount), 0);
      nReset = 1;
      step(2);

      // First-sample latency and justification
      adcDatabus = 10'h155; runFlag = 1; sampleBus.sampleReady = 1;
      step(1);
      checkValue("lat_valid0", 32'(sampleBus.sampleValid), 0);
      step(1);
      checkValue("lat_valid", 32'(sampleBus.sampleValid), 1);
      checkValue("lat_data", 32'(sampleBus.sampleData), 32'h5540);
      checkValue("lat_ovf", 32'(overflow), 0);
      step(6);
      goIdle();

      // Overflow with stalled consumer
      runFlag = 1; sampleBus.sampleReady = 0;
      for (int i = 0; i < 5; i++) begin
         adcDatabus = ADC_W'($urandom_range(1, ALL_ONES - 1));
         step(1);
      end
      checkValue("ovf_before", 32'(overflow), 0);
      adcDatabus = 10'h0AA;
      step(1);
      checkValue("ovf_set", 32'(overflow), 1);
      runFlag = 0;
      step(2);
      sampleBus.sampleReady = 1;
      step(10);
      checkValue("ovf_sticky", 32'(overflow), 1);
      checkValue("ovf_drained", 32'(sampleBus.sampleValid), 0);

      // Clip counting and clear on restart
      runFlag = 1;
      for (int i = 0; i < 9; i++) begin
         adcDatabus = clipPat[i % 3];
         step(1);
      end
      runFlag = 0;
      step(4);
      checkValue("clip_six", 32'(clipCount), 6);
      goIdle();
      adcDatabus = 10'h123; runFlag = 1;
      step(1);
      checkValue("clip_clear", 32'(clipCount), 0);
      checkValue("ovf_clear", 32'(overflow), 0);
      goIdle();

      // Flush with queued entries, runFlag re-raised during flush
      runFlag = 1; sampleBus.sampleReady = 0;
      for (int i = 0; i < 4; i++) begin
         adcDatabus = ADC_W'($urandom);
         step(1);
      end
      runFlag = 0; sampleBus.sampleReady = 1;
      step(1);
      runFlag = 1; adcDatabus = 10'h321;
      step(8);
      goIdle();

`ifdef ADC_TEST_PATTERN_EN
      testMode = 1; runFlag = 1; sampleBus.sampleReady = 1;
      step(1030);
      goIdle();
`endif

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) runFlag = ~runFlag;
         sampleBus.sampleReady = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 7))
            0: adcDatabus = '0;
            1: adcDatabus = '1;
            default: adcDatabus = ADC_W'($urandom);
         endcase
         testMode = 1'($urandom);
         step(1);
      end
      goIdle();

      // Asynchronous reset mid-run with a full FIFO
      runFlag = 1; sampleBus.sampleReady = 0; adcDatabus = '0;
      step(8);
      #2 nReset = 0;
      #1;
      checkValue("arst_valid", 32'(sampleBus.sampleValid), 0);
      checkValue("arst_data", 32'(sampleBus.sampleData), 0);
      checkValue("arst_ovf", 32'(overflow), 0);
      checkValue("arst_clip", 32'(clipCount), 0);
      modelReset();
      step(2);
      nReset = 1; sampleBus.sampleReady = 1; adcDatabus = 10'h2A5;
      step(2);
      checkValue("arst_resume", 32'(sampleBus.sampleValid), 1);
      step(4);
      goIdle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/adc_capture_fifo.md
# adc_capture_fifo

Parametrised ADC capture front end, successor to the fixed 10-to-16-bit capture stage. It samples an ADC_WIDTH-bit bus on the falling clock edge while run is asserted and left-justifies each sample to OUT_WIDTH bits. Samples pass through a FIRST-word-fall-through FIFO to a valid/ready consumer, with a sticky overflow flag and a saturating clip counter. It sits between the ADC pins and the USB/FX3 transfer logic.

## Interface
- ADC_WIDTH, 10, ADC data bus width (2..16)
- OUT_WIDTH, 16, output sample width (>= ADC_WIDTH)
- FIFO_DEPTH, 4, FIFO entries (power of two, >= 2)
- clock  in  1  sample clock; all logic on negedge
- nReset  in  1  reset nReset, asynchronous, active-low
- runFlag  in  1  capture enable
- testMode  in  1  select test counter instead of ADC bus (see Configuration)
- adcDatabus  in  ADC_WIDTH  raw ADC data, valid at falling edge
- sampleReady  in  1  consumer ready
- sampleData  out  OUT_WIDTH  FIFO head sample
- sampleValid  out  1  sampleData holds a valid sample
- overflow  out  1  sticky: at least one sample dropped this run
- clipCount  out  16  samples at all-zeros or all-ones this run, saturating

## Operation
- States: IDLE, RUN, FLUSH. Reset -> IDLE.
- IDLE: no capture. On a negedge with runFlag=1: -> RUN. On that same edge, clear overflow, clipCount and test counter, and capture the first sample.
- RUN: capture one sample every negedge while runFlag=1. On a negedge with runFlag=0: no capture, -> FLUSH.
- FLUSH: no capture; consumer drains FIFO. FIFO empty and input stage empty -> IDLE. runFlag is ignored in FLUSH; a high runFlag is acted on from IDLE on the next edge.
- Pipeline: capture edge loads input register (data + valid bit). Next negedge writes it to the FIFO.
- Justification: written value = captured << (OUT_WIDTH-ADC_WIDTH), low bits zero. Defaults reproduce x64 (10->16 bits).
- Clip: evaluated at the FIFO-write stage. Captured value all-zeros or all-ones -> clipCount+1, holding at 0xFFFF.
- FIFO write when full:
  - a pop on the same edge frees space, so the write succeeds;
  - otherwise the sample is dropped and overflow is set.
- Dropped samples are still clip-counted.
- Pop: on a negedge with sampleValid=1 and sampleReady=1. sampleValid=0 means sampleReady is ignored.
- overflow and clipCount hold their values through FLUSH and IDLE until the next IDLE->RUN.

## Timing
- Reset values: sampleData=0, sampleValid=0, overflow=0, clipCount=0, FIFO empty, input register invalid, test counter 0.
- Latency: value captured at negedge n, FIFO empty, no stall -> sampleData/sampleValid updated after negedge n+1.
- Full rate: with sampleReady held high, one sample per clock, no drops.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits, so wrap-around distinguishes full from empty.
- Reset mid-run: FIFO contents discarded, all outputs return to reset values asynchronously.

## Configuration
- ADC_TEST_PATTERN_EN defined:
  - testMode=1 during capture loads an ADC_WIDTH-bit counter instead of adcDatabus.
  - Counter starts at 0 on IDLE->RUN, increments per capture, wraps at 2^ADC_WIDTH-1 -> 0.
  - testMode=0 captures adcDatabus.
- ADC_TEST_PATTERN_EN undefined: testMode ignored; counter logic absent; adcDatabus always captured.

## Test plan
- Defaults: adcDatabus=0x155, runFlag=1, sampleReady=1 -> sampleData=0x5540 and sampleValid=1 two negedges after runFlag seen; overflow=0.
- sampleReady=0, 6 captures, FIFO_DEPTH=4 -> 4 samples retained in order; overflow=1 after 5th capture edge + 1; overflow stays 1 after drain and in IDLE.
- Bus pattern 0x000, 0x3FF, 0x200 repeated 3 times -> clipCount=6. Next IDLE->RUN -> clipCount=0.
- runFlag dropped with 3 entries queued, sampleReady=1 -> 3 further pops, no new samples, state reaches IDLE. runFlag high during FLUSH is not captured until after IDLE.
- ADC_TEST_PATTERN_EN, testMode=1, ADC_WIDTH=10 -> sampleData sequence 0x0000, 0x0040, ..., 0xFFC0, then wraps to 0x0000 on the 1025th sample.
- nReset pulsed low mid-run with a full FIFO -> sampleValid=0, overflow=0, clipCount=0 immediately; capture resumes from IDLE with runFlag=1 after release.
